alu_serial_ctrl: RTL and testbench
==================================

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have ports:
  clk_i  in  1  clock
  rst_i  in  1  synchronous active-high reset
  start_i  in  1  request; sampled only in IDLE
  src1_i  in  32  operand A
  src2_i  in  32  operand B
  ALU_control_i  in  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
  slice_src1_o  out  1  A bit to 1-bit ALU slice
  slice_src2_o  out  1  B bit to slice
  slice_less_o  out  1  less input to slice
  slice_A_invert_o  out  1  slice A invert
  slice_B_invert_o  out  1  slice B invert
  slice_cin_o  out  1  slice carry-in
  slice_operation_o  out  2  slice op: 00 AND, 01 OR, 10 ADD, 11 LESS
  slice_result_i  in  1  slice result bit
  slice_cout_i  in  1  slice carry-out
  busy_o  out  1  operation in progress
  done_o  out  1  one-cycle completion pulse
  result_o  out  32  final result
  zero_o  out  1  result_o == 0
  cout_o  out  1  final carry (ADD/SUB/SLT), else 0
  overflow_o  out  1  signed overflow (ADD/SUB/SLT), else 0

Function
REQ-003 SHALL implement states IDLE, RUN, SLT_FIX, DONE.
REQ-004 IDLE with start_i=1 SHALL latch src1_i, src2_i, ALU_control_i, clear bit index k to 0 and carry register to 0, and go to RUN.
REQ-005 Decode SHALL be: AND {Ainv 0, Binv 0, op 00}; OR {0,0,01}; ADD {0,0,10}; SUB {0,1,10}; SLT {0,1,10} in RUN; NOR {1,1,00}; any other code SHALL decode as AND.
REQ-006 In RUN, slice_src1_o/slice_src2_o SHALL drive latched operand bit k; slice_cin_o SHALL be Binv at k=0, else carry register; slice_less_o SHALL be 0.
REQ-007 Each RUN cycle SHALL capture slice_result_i into result bit k and slice_cout_i into carry register, then increment k.
REQ-008 At k=31 SHALL compute overflow = slice_cin_o ^ slice_cout_i and set = slice_result_i ^ overflow; carry-out = slice_cout_i.
REQ-009 After k=31 RUN SHALL go to SLT_FIX for SLT, else DONE.
REQ-010 SLT_FIX SHALL last one cycle: slice_operation_o=11, slice_less_o=set, src bits 0, inverts 0, cin 0; result bit 0 SHALL be slice_result_i, bits 31:1 SHALL be 0.
REQ-011 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-012 result_o, zero_o, cout_o, overflow_o SHALL update together on entry to DONE and hold until the next DONE or reset.
REQ-013 busy_o SHALL be 1 in RUN and SLT_FIX, 0 otherwise.
REQ-014 Latency: start sampled at edge 0 -> done_o high in cycle 33 (non-SLT) or 34 (SLT).
REQ-015 start_i outside IDLE SHALL be ignored, including in DONE; no queuing.
REQ-016 In IDLE and DONE all slice_* outputs SHALL be 0.
REQ-017 ADD/SUB carry chain SHALL be 32-bit modulo; cout_o and overflow_o SHALL be 0 for AND/OR/NOR/unsupported codes.

Reset
REQ-018 rst_i=1 at a clock edge SHALL force IDLE, k=0, carry 0, and all outputs 0 (zero_o included), regardless of state.
REQ-019 Reset mid-RUN or mid-SLT_FIX SHALL abort without a done_o pulse; partial results SHALL not appear on result_o.

Verification
REQ-020 ADD 0x7FFFFFFF + 0x00000001 -> result_o 0x80000000, overflow_o 1, cout_o 0, zero_o 0, done_o in cycle 33.
REQ-021 SUB 0x00000005 - 0x00000005 -> result_o 0, zero_o 1, cout_o 1, overflow_o 0.
REQ-022 SLT 0xFFFFFFFF vs 0x00000001 -> result_o 1, done_o in cycle 34; SLT 0x80000000 vs 0x00000001 -> result_o 1 (overflow_o 1); SLT 5 vs 3 -> result_o 0.
REQ-023 NOR 0x0F0F0000, 0x00FF0000 -> result_o 0xF000FFFF, cout_o 0, overflow_o 0; OR same operands -> 0x0FFF0000.
REQ-024 Start ADD, pulse start_i with new operands in RUN cycle 5 -> ignored, original result returned; assert rst_i in RUN cycle 10 -> busy_o 0, all outputs 0, no done_o.
REQ-025 Code 1111 with 0xFF00FF00, 0x0FF00FF0 -> result_o 0x0F000F00 (AND behaviour), done_o in cycle 33.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - bit-serial 32-bit ALU sequencer driving an external 1-bit ALU slice
module alu_serial_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic [3:0]  ALU_control_i,
    output logic        slice_src1_o,
    output logic        slice_src2_o,
    output logic        slice_less_o,
    output logic        slice_A_invert_o,
    output logic        slice_B_invert_o,
    output logic        slice_cin_o,
    output logic [1:0]  slice_operation_o,
    input  logic        slice_result_i,
    input  logic        slice_cout_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic        cout_o,
    output logic        overflow_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_SLT_FIX = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, b_q, acc_q;
    logic [3:0]  ctrl_q;
    logic [4:0]  k_q;
    logic        carry_q, set_q, ovf_q, cout_q;

    logic        a_inv, b_inv, is_arith, is_slt;
    logic [1:0]  op_code;
    logic        cin_run, last_bit, run_ovf;
    logic [31:0] run_final;

    always_comb begin
        a_inv    = 1'b0;
        b_inv    = 1'b0;
        op_code  = 2'b00;
        is_arith = 1'b0;
        is_slt   = 1'b0;
        case (ctrl_q)
            4'b0001: op_code = 2'b01;
            4'b0010: begin op_code = 2'b10; is_arith = 1'b1; end
            4'b0110: begin op_code = 2'b10; is_arith = 1'b1; b_inv = 1'b1; end
            4'b0111: begin op_code = 2'b10; is_arith = 1'b1; b_inv = 1'b1; is_slt = 1'b1; end
            4'b1100: begin a_inv = 1'b1; b_inv = 1'b1; end
            default: ;
        endcase
    end

    // Bit 0 takes the subtract "+1" from B-invert; later bits chain the stored carry.
    assign cin_run   = (k_q == 5'd0) ? b_inv : carry_q;
    assign last_bit  = (k_q == 5'd31);
    assign run_ovf   = cin_run ^ slice_cout_i;
    assign run_final = acc_q | {slice_result_i, 31'b0};

    always_comb begin
        state_d           = state_q;
        slice_src1_o      = 1'b0;
        slice_src2_o      = 1'b0;
        slice_less_o      = 1'b0;
        slice_A_invert_o  = 1'b0;
        slice_B_invert_o  = 1'b0;
        slice_cin_o       = 1'b0;
        slice_operation_o = 2'b00;
        busy_o            = 1'b0;
        done_o            = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                busy_o            = 1'b1;
                slice_src1_o      = a_q[k_q];
                slice_src2_o      = b_q[k_q];
                slice_A_invert_o  = a_inv;
                slice_B_invert_o  = b_inv;
                slice_cin_o       = cin_run;
                slice_operation_o = op_code;
                if (last_bit) state_d = is_slt ? S_SLT_FIX : S_DONE;
            end
            S_SLT_FIX: begin
                busy_o            = 1'b1;
                slice_operation_o = 2'b11;
                slice_less_o      = set_q;
                state_d           = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            ctrl_q     <= '0;
            acc_q      <= '0;
            k_q        <= '0;
            carry_q    <= 1'b0;
            set_q      <= 1'b0;
            ovf_q      <= 1'b0;
            cout_q     <= 1'b0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            cout_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_q     <= src1_i;
                        b_q     <= src2_i;
                        ctrl_q  <= ALU_control_i;
                        acc_q   <= '0;
                        k_q     <= '0;
                        carry_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    acc_q[k_q] <= slice_result_i;
                    carry_q    <= slice_cout_i;
                    k_q        <= k_q + 5'd1;
                    if (last_bit) begin
                        set_q  <= slice_result_i ^ run_ovf;
                        ovf_q  <= run_ovf;
                        cout_q <= slice_cout_i;
                        // SLT results are published from SLT_FIX instead.
                        if (!is_slt) begin
                            result_o   <= run_final;
                            zero_o     <= (run_final == 32'd0);
                            cout_o     <= is_arith & slice_cout_i;
                            overflow_o <= is_arith & run_ovf;
                        end
                    end
                end
                S_SLT_FIX: begin
                    result_o   <= {31'b0, slice_result_i};
                    zero_o     <= ~slice_result_i;
                    cout_o     <= cout_q;
                    overflow_o <= ovf_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb/tb_alu_serial_ctrl.sv - self-checking bench for alu_serial_ctrl with a 1-bit slice model
module tb_alu_serial_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] src1_i, src2_i;
    logic [3:0]  ALU_control_i;
    logic        slice_src1_o, slice_src2_o, slice_less_o;
    logic        slice_A_invert_o, slice_B_invert_o, slice_cin_o;
    logic [1:0]  slice_operation_o;
    logic        slice_result_i, slice_cout_i;
    logic        busy_o, done_o, zero_o, cout_o, overflow_o;
    logic [31:0] result_o;

    always #5 clk_i = ~clk_i;

    alu_serial_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .src1_i(src1_i), .src2_i(src2_i), .ALU_control_i(ALU_control_i),
        .slice_src1_o(slice_src1_o), .slice_src2_o(slice_src2_o),
        .slice_less_o(slice_less_o), .slice_A_invert_o(slice_A_invert_o),
        .slice_B_invert_o(slice_B_invert_o), .slice_cin_o(slice_cin_o),
        .slice_operation_o(slice_operation_o),
        .slice_result_i(slice_result_i), .slice_cout_i(slice_cout_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
        .zero_o(zero_o), .cout_o(cout_o), .overflow_o(overflow_o)
    );

    // Behavioural 1-bit ALU slice
    logic sa, sb;
    assign sa = slice_src1_o ^ slice_A_invert_o;
    assign sb = slice_src2_o ^ slice_B_invert_o;
    assign slice_cout_i = (sa & sb) | (sa & slice_cin_o) | (sb & slice_cin_o);
    always_comb begin
        slice_result_i = 1'b0;
        case (slice_operation_o)
            2'b00: slice_result_i = sa & sb;
            2'b01: slice_result_i = sa | sb;
            2'b10: slice_result_i = sa ^ sb ^ slice_cin_o;
            2'b11: slice_result_i = slice_less_o;
            default: ;
        endcase
    end

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        cout;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;

    function automatic exp_t ref_alu(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [32:0] s;
        e.cout = 1'b0;
        e.ovf  = 1'b0;
        e.lat  = 33;
        case (ctrl)
            4'b0001: e.result = a | b;
            4'b1100: e.result = ~(a | b);
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                e.result = s[31:0];
                e.cout = s[32];
                e.ovf  = (a[31] == b[31]) && (s[31] != a[31]);
            end
            4'b0110, 4'b0111: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.cout = s[32];
                e.ovf  = (a[31] != b[31]) && (s[31] != a[31]);
                if (ctrl == 4'b0111) begin
                    e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    e.lat = 34;
                end else begin
                    e.result = s[31:0];
                end
            end
            default: e.result = a & b;
        endcase
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [7:0] slice_bus();
        return {slice_src1_o, slice_src2_o, slice_less_o, slice_A_invert_o,
                slice_B_invert_o, slice_cin_o, slice_operation_o};
    endfunction

    task automatic run_op(input string name, input logic [3:0] ctrl, input logic [31:0] a,
                          input logic [31:0] b, input int inject_at);
        exp_t e;
        int   cyc;
        logic got;
        sb_q.push_back(ref_alu(ctrl, a, b));
        @(negedge clk_i);
        src1_i = a; src2_i = b; ALU_control_i = ctrl; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (cyc < 60 && !got) begin
            @(negedge clk_i);
            cyc++;
            start_i = 1'b0;
            if (cyc == 1) check({name, ":busy_c1"}, {31'b0, busy_o}, 32'd1);
            if (cyc == 2) begin src1_i = $urandom; src2_i = $urandom; ALU_control_i = 4'b0000; end
            if (cyc == inject_at) begin
                src1_i = $urandom; src2_i = $urandom; ALU_control_i = 4'b0010; start_i = 1'b1;
            end
            if (cyc == 33 && ctrl == 4'b0111)
                check({name, ":sltfix_op"}, {30'b0, slice_operation_o}, 32'd3);
            if (done_o) got = 1'b1;
        end
        start_i = 1'b0;
        if (!got || sb_q.size() == 0) begin
            check({name, ":done_seen"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({name, ":latency"}, cyc, e.lat);
            check({name, ":result"}, result_o, e.result);
            check({name, ":flags"}, {29'b0, zero_o, cout_o, overflow_o}, {29'b0, e.zero, e.cout, e.ovf});
            check({name, ":done_slice"}, {23'b0, busy_o, slice_bus()}, 32'd0);
            @(negedge clk_i);
            check({name, ":done_width"}, {31'b0, done_o}, 32'd0);
            check({name, ":hold"}, result_o, e.result);
        end
    endtask

    task automatic run_reset(input string name, input logic [3:0] ctrl, input logic [31:0] a,
                             input logic [31:0] b, input int rst_at);
        int   cyc;
        logic saw_done;
        @(negedge clk_i);
        src1_i = a; src2_i = b; ALU_control_i = ctrl; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        for (cyc = 1; cyc < rst_at; cyc++) @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check({name, ":busy"}, {31'b0, busy_o}, 32'd0);
        check({name, ":outs"}, {result_o ^ 32'd0}, 32'd0);
        check({name, ":flags"}, {28'b0, done_o, zero_o, cout_o, overflow_o}, 32'd0);
        check({name, ":slice"}, {24'b0, slice_bus()}, 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (done_o) saw_done = 1'b1;
        end
        check({name, ":no_done"}, {31'b0, saw_done}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; src1_i = '0; src2_i = '0; ALU_control_i = '0;
        repeat (3) @(negedge clk_i);
        check("reset:outs", result_o, 32'd0);
        check("reset:flags", {27'b0, busy_o, done_o, zero_o, cout_o, overflow_o}, 32'd0);
        check("reset:slice", {24'b0, slice_bus()}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        run_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op("sub_zero", 4'b0110, 32'h0000_0005, 32'h0000_0005, 0);
        run_op("slt_neg",  4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op("slt_ovf",  4'b0111, 32'h8000_0000, 32'h0000_0001, 0);
        run_op("slt_ge",   4'b0111, 32'h0000_0005, 32'h0000_0003, 0);
        run_op("nor",      4'b1100, 32'h0F0F_0000, 32'h00FF_0000, 0);
        run_op("or",       4'b0001, 32'h0F0F_0000, 32'h00FF_0000, 0);
        run_op("and",      4'b0000, 32'hF0F0_1234, 32'hFF00_FFFF, 0);
        run_op("bad_code", 4'b1111, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
        run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op("sub_neg",  4'b0110, 32'h0000_0000, 32'h0000_0001, 0);
        run_op("add_inj",  4'b0010, 32'h1234_5678, 32'h0101_0101, 5);
        for (int i = 0; i < 4; i++) begin
            run_op("rnd_add", 4'b0010, $urandom, $urandom, 0);
            run_op("rnd_sub", 4'b0110, $urandom, $urandom, 0);
            run_op("rnd_slt", 4'b0111, $urandom, $urandom, 0);
        end
        run_reset("rst_run", 4'b0010, 32'h1111_1111, 32'h2222_2222, 10);
        run_op("after_rst", 4'b0010, 32'h0000_0010, 32'h0000_0020, 0);
        run_reset("rst_fix", 4'b0111, 32'h0000_0001, 32'h0000_0002, 33);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
